// File: rtl/npu_pkg.sv
// Shared NPU definitions: default map geometry, reader FSM states and the
// index-width helper used by the buffer reader/writer blocks.
package npu_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_H          = 14;
  localparam int DEF_W          = 13;

  // Width of an index that must address n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = idx_w(DEF_H);
  localparam int COL_W = idx_w(DEF_W);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } reader_state_e;

endpackage

// File: rtl/buffer_stream_reader_if.sv
// Map-in / element-out handshake bundle of the feature-map buffer reader.
// slave: the reader itself; master: whoever supplies maps and consumes beats.
interface buffer_stream_reader_if #(
  parameter int DATA_WIDTH = npu_pkg::DEF_DATA_WIDTH,
  parameter int H          = npu_pkg::DEF_H,
  parameter int W          = npu_pkg::DEF_W
);

  localparam int ROW_BITS = npu_pkg::idx_w(H);
  localparam int COL_BITS = npu_pkg::idx_w(W);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data [H][W];
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [ROW_BITS-1:0]          out_row;
  logic [COL_BITS-1:0]          out_col;
  logic                         out_row_last;
  logic                         out_last;
  logic                         done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col,
           out_row_last, out_last, done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col,
           out_row_last, out_last, done
  );

endinterface

// File: rtl/buffer_stream_reader_raster_counter.sv
// Row/column raster counter over an H x W map. Wraps correctly for
// non-power-of-two H and W; clear has priority over advance.
module raster_counter
  import npu_pkg::*;
#(
  parameter int H = DEF_H,
  parameter int W = DEF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [idx_w(H)-1:0]   row_o,
  output logic [idx_w(W)-1:0]   col_o,
  output logic                  row_last_o,
  output logic                  last_o
);

  localparam int ROW_BITS = idx_w(H);
  localparam int COL_BITS = idx_w(W);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(H - 1);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(W - 1);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;

  // Next position: column steps first, row steps on column wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign row_last_o = (col_q == COL_MAX);
  assign last_o     = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/buffer_stream_reader.sv
// Feature-map buffer reader: captures a whole H x W map in one cycle and
// streams it out one element per accepted beat in raster order.
module buffer_stream_reader
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H          = DEF_H,
  parameter int W          = DEF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  buffer_stream_reader_if.slave bus
);

  localparam int ROW_BITS = idx_w(H);
  localparam int COL_BITS = idx_w(W);

  reader_state_e state_q, state_d;
  logic          done_q, done_d;
  logic          capture;
  logic          clear;
  logic          advance;
  logic          stream_active;

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                row_last;
  logic                last;

  logic signed [DATA_WIDTH-1:0] storage_q [H][W];

  raster_counter #(
    .H (H),
    .W (W)
  ) u_raster_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .advance_i  (advance),
    .row_o      (row),
    .col_o      (col),
    .row_last_o (row_last),
    .last_o     (last)
  );

  // FSM next state: IDLE waits for a map, STREAM walks it beat by beat.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    capture = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          clear   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          advance = 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and done pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Map storage, loaded whole in the capture cycle.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; it is only read after a capture has written every entry.
    if (capture) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          storage_q[r][c] <= bus.in_data[r][c];
        end
      end
    end
  end

  assign stream_active    = (state_q == STREAM);
  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = stream_active;
  assign bus.out_data     = stream_active ? storage_q[row][col] : '0;
  assign bus.out_row      = row;
  assign bus.out_col      = col;
  assign bus.out_row_last = stream_active & row_last;
  assign bus.out_last     = stream_active & last;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Self-checking bench for buffer_stream_reader: a linear-index model of the
// map stream is compared against the DUT on every cycle, and directed
// scenarios pin beat counts, timing and boundary values with literals.
module tb_buffer_stream_reader;
  import npu_pkg::*;

  localparam int DW = 24;
  localparam int H  = 14;
  localparam int W  = 13;
  localparam int N  = H * W;

  typedef logic signed [DW-1:0] map_t [H][W];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  buffer_stream_reader_if #(.DATA_WIDTH(DW), .H(H), .W(W)) bus ();

  buffer_stream_reader #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: busy flag, linear beat index and the captured map.
  map_t m_map;
  bit   m_busy = 1'b0;
  int   m_idx  = 0;
  bit   m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_idx  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bus.out_ready) begin
          if (m_idx == N - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end else if (bus.in_valid) begin
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            m_map[r][c] = bus.in_data[r][c];
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
  end

  // Observed traffic for the directed checks.
  logic [DW-1:0] beats[$];
  int            beats_cyc[$];
  logic [DW-1:0] rl_vals[$];
  logic [DW-1:0] last_vals[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            cap_cyc  = 0;

  // Per-cycle compare against the model plus beat collection.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_busy));
      check("in_ready", 32'(bus.in_ready), 32'(!m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      if (m_busy) begin
        check("out_data", {8'h0, bus.out_data}, {8'h0, m_map[m_idx / W][m_idx % W]});
        check("out_row", 32'(bus.out_row), 32'(m_idx / W));
        check("out_col", 32'(bus.out_col), 32'(m_idx % W));
        check("out_row_last", 32'(bus.out_row_last), 32'((m_idx % W) == W - 1));
        check("out_last", 32'(bus.out_last), 32'(m_idx == N - 1));
      end
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back(bus.out_data);
        beats_cyc.push_back(cyc);
        if (bus.out_row_last) rl_vals.push_back(bus.out_data);
        if (bus.out_last) last_vals.push_back(bus.out_data);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    beats.delete();
    beats_cyc.delete();
    rl_vals.delete();
    last_vals.delete();
    done_cnt = 0;
  endtask

  task automatic drive_map(input map_t m);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        bus.in_data[r][c] = m[r][c];
  endtask

  task automatic load_map(input map_t m);
    int n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("load_timeout", 32'(n), 32'(0));
    drive_map(m);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    cap_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggling 1,0,1,0, 2: random.
  task automatic stream(input int mode, input int budget);
    int n  = 0;
    int d0 = done_cnt;
    bit ph = 1'b1;
    while (done_cnt == d0 && n < budget) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ph;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      ph = !ph;
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check("stream_timeout", 32'(n), 32'(budget));
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check("beat_timeout", 32'(beats.size()), 32'(target));
  endtask

  task automatic check_seq(input string name, input map_t m);
    int bad = 0;
    check({name, "_count"}, 32'(beats.size()), 32'(N));
    for (int k = 0; k < beats.size() && k < N; k++)
      if (beats[k] !== m[k / W][k % W]) bad++;
    check({name, "_mismatches"}, 32'(bad), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
    check({tag, "_done"}, 32'(bus.done), 32'(0));
    check({tag, "_out_data"}, {8'h0, bus.out_data}, 32'(0));
    check({tag, "_out_row"}, 32'(bus.out_row), 32'(0));
    check({tag, "_out_col"}, 32'(bus.out_col), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    map_t inc_map, neg_map, edge_map, rnd_map, new_map;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        inc_map[r][c] = DW'(r * W + c);
        neg_map[r][c] = '1;
      end
    edge_map       = inc_map;
    edge_map[0][0] = -24'sd4;
    edge_map[H-1][W-1] = 24'sh800000;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_map(inc_map);
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("por");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Raster stream with ready held high.
    clear_stats();
    bus.out_ready = 1'b1;
    load_map(inc_map);
    stream(0, 400);
    check_seq("inc", inc_map);
    check("first_beat_cycle", 32'(beats_cyc[0]), 32'(cap_cyc));
    check("beat_span", 32'(beats_cyc[N-1] - beats_cyc[0]), 32'(N - 1));
    check("beat0_value", {8'h0, beats[0]}, 32'd0);
    check("beat181_value", {8'h0, beats[N-1]}, 32'd181);
    check("row_last_count", 32'(rl_vals.size()), 32'd14);
    check("row_last_first", {8'h0, rl_vals[0]}, 32'd12);
    check("row_last_second", {8'h0, rl_vals[1]}, 32'd25);
    check("last_count", 32'(last_vals.size()), 32'd1);
    check("last_value", {8'h0, last_vals[0]}, 32'd181);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(beats_cyc[N-1] + 1));

    // Toggling backpressure.
    clear_stats();
    load_map(inc_map);
    stream(1, 800);
    check_seq("toggle", inc_map);
    check("toggle_done_count", 32'(done_cnt), 32'd1);

    // New map offered mid-stream must be ignored.
    clear_stats();
    load_map(inc_map);
    drive_map(neg_map);
    bus.in_valid = 1'b1;
    repeat (20) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'(0));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    stream(0, 400);
    check_seq("ignore", inc_map);

    // Signed extremes at the first and last positions.
    clear_stats();
    load_map(edge_map);
    stream(0, 400);
    check("edge_beat0", {8'h0, beats[0]}, 32'h00FFFFFC);
    check("edge_beat181", {8'h0, beats[N-1]}, 32'h00800000);

    // Random maps with random backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          rnd_map[r][c] = DW'($urandom);
      clear_stats();
      load_map(rnd_map);
      stream(2, 2000);
      check_seq("random", rnd_map);
    end

    // Mid-cycle reset after beat 50, then a fresh map.
    clear_stats();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        new_map[r][c] = DW'($urandom);
    load_map(rnd_map);
    bus.out_ready = 1'b1;
    wait_beats(51, 200);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    #14 rst = 1'b0;
    @(posedge clk); #1;
    clear_stats();
    load_map(new_map);
    stream(0, 400);
    check_seq("after_reset", new_map);
    check("after_reset_beat0", {8'h0, beats[0]}, {8'h0, new_map[0][0]});

    // Back-to-back maps with in_valid held high.
    clear_stats();
    drive_map(rnd_map);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    wait_beats(N + 1, 600);
    bus.in_valid = 1'b0;
    stream(0, 400);
    check("b2b_beats", 32'(beats.size()), 32'(2 * N));
    check("b2b_gap", 32'(beats_cyc[N] - beats_cyc[N-1]), 32'd2);
    check("b2b_second_first", {8'h0, beats[N]}, {8'h0, rnd_map[0][0]});
    check("b2b_done_count", 32'(done_cnt), 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
